// File: rtl/rotseq_pkg.sv
// Shared types and widths for the rotate sequencer that drives the 4-bit barrel shifter.
package rotseq_pkg;
  localparam int ROT_W = 4;
  localparam int AMT_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;
endpackage

// File: rtl/rotate_sequencer.sv
// Feeds the external barrel_shifter, waits SETTLE_CYC cycles, then captures its output
// and hands it downstream. Optional macro ROTSEQ_LEFT_EN adds the in_dir port for left rotation.
module rotate_sequencer
  import rotseq_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROT_W-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
`ifdef ROTSEQ_LEFT_EN
  input  logic             in_dir,
`endif
  output logic [ROT_W-1:0] sh_a,
  output logic [AMT_W-1:0] sh_s,
  input  logic [ROT_W-1:0] sh_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROT_W-1:0] out_data,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [AMT_W-1:0] amt;

`ifdef ROTSEQ_LEFT_EN
  // Left by n equals right by (4-n) mod 4; the 2-bit wrap does the modulo.
  assign amt = in_dir ? ('0 - in_amt) : in_amt;
`else
  assign amt = in_amt;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sh_a      <= '0;
      sh_s      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sh_a  <= in_data;
          sh_s  <= amt;
          cnt   <= SETTLE_LD;
          state <= SETTLE;
        end
        SETTLE: begin
          if (cnt == '0) begin
            out_data  <= sh_y;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // sh_a/sh_s are left untouched so the shifter output stays quiet.
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          op_count  <= op_count + 1'b1;
          state     <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
